// File: rtl/add_share_arb_pkg.sv
// Shared types and helpers for add_share_arb: FSM state encoding, datapath width,
// and the carry/overflow equations used when ADD_ARB_FLAGS_EN is defined.
package add_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // CLA16b has no carry-out port, so it is rebuilt from the operand and sum MSBs.
  function automatic logic add_cout(input logic a15, input logic b15, input logic s15);
    return (a15 & b15) | ((a15 ^ b15) & ~s15);
  endfunction

  function automatic logic add_ovf(input logic a15, input logic b15, input logic s15);
    return (a15 == b15) & (s15 != a15);
  endfunction

endpackage

// File: rtl/add_share_arb_cla16b.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with group
// propagate/generate chained across the groups.
module CLA16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] w_p;
  logic [15:0] w_g;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Per-group carries expanded from each group's carry-in
  always_comb begin
    logic [16:0] c;
    c    = 17'd0;
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = w_g[4*k] | (w_p[4*k] & c[4*k]);
      c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
               | (w_p[4*k+1] & w_p[4*k] & c[4*k]);
      c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
               | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
               | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
      c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
               | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
               | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
               | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
    end
    sum = w_p ^ c[15:0];
  end

endmodule

// File: rtl/add_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// at or after ptr, wrapping from N-1 to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_first;
  logic [2*N-1:0] w_gnt_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign w_dbl     = {req, req} >> ptr;
  assign w_rot     = w_dbl[N-1:0];
  assign w_first   = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});
  assign w_gnt_dbl = {w_first, w_first} << ptr;
  assign gnt       = w_gnt_dbl[2*N-1:N];

endmodule

// File: rtl/add_share_arb.sv
// Round-robin shared 16-bit adder with tagged valid/ready response.
// Define ADD_ARB_FLAGS_EN to add the rsp_cout / rsp_ovf flag outputs.
module add_share_arb
  import add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]             req_cin,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_W-1:0]              rsp_sum,
`ifdef ADD_ARB_FLAGS_EN
  output logic                           rsp_cout,
  output logic                           rsp_ovf,
`endif
  output logic [ID_W-1:0]                rsp_id
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_cin;
  logic [ID_W-1:0]     r_id;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_sum;
  logic [ID_W-1:0]     r_rsp_id;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [DATA_W-1:0]   w_sum;
  logic                w_xfer;

  rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_gnt)
  );

  CLA16b u_cla (
    .a   (r_a),
    .b   (r_b),
    .cin (r_cin),
    .sum (w_sum)
  );

  // One-hot grant to requester index
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx = ID_W'(i);
      end else begin
        w_gnt_idx = w_gnt_idx;
      end
    end
  end

  assign w_xfer = (r_state == IDLE) & rst_n & (|w_gnt);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decode
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          req_ready = w_gnt;
        end else begin
          req_ready = '0;
        end
        if (w_xfer) begin
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, pointer advance, and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_xfer) begin
        r_a      <= req_a[w_gnt_idx];
        r_b      <= req_b[w_gnt_idx];
        r_cin    <= req_cin[w_gnt_idx];
        r_id     <= w_gnt_idx;
        r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
      end
      if (r_state == CALC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_sum   <= w_sum;
        r_rsp_id    <= r_id;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ADD_ARB_FLAGS_EN
  logic r_rsp_cout;
  logic r_rsp_ovf;

  // Flags registered alongside the sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_cout <= 1'b0;
      r_rsp_ovf  <= 1'b0;
    end else if (r_state == CALC) begin
      r_rsp_cout <= add_cout(r_a[DATA_W-1], r_b[DATA_W-1], w_sum[DATA_W-1]);
      r_rsp_ovf  <= add_ovf(r_a[DATA_W-1], r_b[DATA_W-1], w_sum[DATA_W-1]);
    end
  end

  assign rsp_cout = r_rsp_cout;
  assign rsp_ovf  = r_rsp_ovf;
`endif

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: transaction-level reference model checked
// every cycle, plus directed cases with literal expectations and a random sweep.
module tb_add_share_arb;

  localparam int N  = 4;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0][15:0]   req_a = '0;
  logic [N-1:0][15:0]   req_b = '0;
  logic [N-1:0]         req_cin = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [15:0]          rsp_sum;
  logic [IW-1:0]        rsp_id;
`ifdef ADD_ARB_FLAGS_EN
  logic                 rsp_cout;
  logic                 rsp_ovf;
`endif

  add_share_arb #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
`ifdef ADD_ARB_FLAGS_EN
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: one operation in flight, response visible two edges after
  // the accepting edge, held until a handshake; rr pointer follows the last grant.
  bit          m_en = 1'b0;
  bit          m_busy = 1'b0;
  int          m_edges = 0;
  int          m_ptr = 0;
  logic [15:0] m_sum = '0;
  int          m_id = 0;
  bit          m_cout = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_resp = 0;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    int           pick;
    int           ssum;
    logic [16:0]  full;
    eg   = '0;
    pick = -1;
    if (rst_n && !m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      end
    end
    if (pick >= 0) eg[pick] = 1'b1;
    if (m_en) begin
      chk("model_req_ready", req_ready, eg);
      chk("model_rsp_valid", rsp_valid, (m_busy && m_edges >= 2));
      if (m_busy && m_edges >= 2) begin
        chk("model_rsp_sum", rsp_sum, m_sum);
        chk("model_rsp_id", rsp_id, m_id);
`ifdef ADD_ARB_FLAGS_EN
        chk("model_rsp_cout", rsp_cout, m_cout);
        chk("model_rsp_ovf", rsp_ovf, m_ovf);
`endif
      end
    end
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_edges = 0;
      m_ptr   = 0;
    end else if (m_busy) begin
      if (m_edges >= 2 && rsp_ready) begin
        m_busy = 1'b0;
        m_resp++;
      end else if (m_edges < 2) begin
        m_edges++;
      end
    end else if (pick >= 0) begin
      m_busy  = 1'b1;
      m_edges = 1;
      m_id    = pick;
      m_ptr   = (pick + 1) % N;
      full    = {1'b0, req_a[pick]} + {1'b0, req_b[pick]} + {16'd0, req_cin[pick]};
      m_sum   = full[15:0];
      m_cout  = full[16];
      ssum    = int'($signed(req_a[pick])) + int'($signed(req_b[pick])) + int'(req_cin[pick]);
      m_ovf   = (ssum > 32767) || (ssum < -32768);
    end
  end

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b, input logic c,
                      output logic [15:0] s, output int id, output int lat);
    bit ok;
    @(posedge clk); #1;
    req_a[i] = a; req_b[i] = b; req_cin[i] = c; req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
    end
    chk("grant_timeout", ok, 1);
    @(posedge clk); #1 req_valid[i] = 1'b0;
    ok = 1'b0; lat = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) ok = 1'b1;
    end
    chk("rsp_timeout", ok, 1);
    s  = rsp_sum;
    id = int'(rsp_id);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] s, s0;
    int          id, id0, lat, n;
    logic [15:0] sums [5];
    int          ids  [5];

    // Reset state, with all requests valid during reset
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_sum", rsp_sum, 16'h0000);
    chk("rst_rsp_id", rsp_id, 2'd0);
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1; m_en = 1'b1;

    // Single request, latency and literal sum
    send(0, 16'h1234, 16'h0001, 1'b0, s, id, lat);
    chk("t1_sum", s, 16'h1235);
    chk("t1_id", id, 0);
    chk("t1_latency", lat, 2);

    // Wrap and flags
    send(1, 16'hFFFF, 16'h0001, 1'b0, s, id, lat);
    chk("wrap_sum", s, 16'h0000);
    chk("wrap_id", id, 1);
`ifdef ADD_ARB_FLAGS_EN
    chk("wrap_cout", rsp_cout, 1'b1);
    chk("wrap_ovf", rsp_ovf, 1'b0);
`endif
    send(2, 16'h7FFF, 16'h0001, 1'b0, s, id, lat);
    chk("ovf_sum", s, 16'h8000);
`ifdef ADD_ARB_FLAGS_EN
    chk("ovf_cout", rsp_cout, 1'b0);
    chk("ovf_ovf", rsp_ovf, 1'b1);
`endif

    // Reset mid-operation (during CALC), pointer left at 3 beforehand
    @(posedge clk); #1;
    req_a[2] = 16'h7FFF; req_b[2] = 16'h7FFF; req_valid[2] = 1'b1;
    @(negedge clk);
    chk("midrst_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready_low", req_ready, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_rsp_sum", rsp_sum, 16'h0000);

    // Fairness from reset: all requesters valid, A=i, B=0x10
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 16'(i); req_b[i] = 16'h0010; req_cin[i] = 1'b0;
    end
    req_valid = 4'b1111;
    @(negedge clk);
    chk("fair_first_grant", req_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      sums[k] = '0; ids[k] = -1;
    end
    n = 0;
    for (int t = 0; t < 60 && n < 5; t++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ids[n] = int'(rsp_id); sums[n] = rsp_sum; n++;
      end
    end
    chk("fair_count", n, 5);
    @(posedge clk); #1 req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      chk("fair_id", ids[k], k % 4);
      chk("fair_sum", sums[k], 16'h0010 + 16'(k % 4));
    end

    // Backpressure: hold RESP for 10 cycles with another request pending
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(1, 16'h0ABC, 16'h0101, 1'b1, s0, id0, lat);
    chk("bp_sum", s0, 16'h0BBE);
    chk("bp_id", id0, 1);
    @(posedge clk); #1 req_valid[3] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_sum", rsp_sum, s0);
      chk("bp_hold_id", rsp_id, id0);
      chk("bp_hold_ready", req_ready, 4'b0000);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1'b1);
    @(negedge clk);
    chk("bp_retired", rsp_valid, 1'b0);
    chk("bp_next_grant", req_ready, 4'b1000);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Random sweep; the model checks every cycle
    for (int t = 0; t < 800; t++) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_a[i]   = 16'($urandom_range(0, 511));
        req_b[i]   = 16'($urandom_range(0, 511));
        req_cin[i] = 1'($urandom_range(0, 1));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    chk("rand_responses_seen", (m_resp > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
